tanh_arbiter: RTL and testbench

TANH_ARBITER -- requirements
Module: tanh_arbiter

---
 rtl/nar_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/tanh_arbiter.sv | 84 ++++++++
 tb/tb_tanh_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/nar_pkg.sv
// Shared definitions for the neuron activation request path: default sizes and
// index <-> one-hot helpers used by the arbiter and response pipeline.
package nar_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W      = 8;

  function automatic logic [7:0] idx2oh(input logic [2:0] idx);
    idx2oh = 8'b1 << idx;
  endfunction

  // Highest set bit wins; callers only pass one-hot or zero vectors.
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    oh2idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) oh2idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority grant: search starts at ptr and wraps.
// Zero latency; emits at most one grant bit, never for an idle requester.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tanh_arbiter.sv
// Shares one negedge tanh LUT among NUM_REQ requesters; 2-edge fixed latency, 1/cycle, no response backpressure.
// Round-robin by default; TANH_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module tanh_arbiter
  import nar_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [8*NUM_REQ-1:0]    req_addr,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [DATA_W-1:0]       lut_addr,
  input  logic [DATA_W-1:0]       lut_data,
  output logic                    busy,
  output logic [CNT_W-1:0]        served_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_arb;
  logic [NUM_REQ-1:0] grant;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [DATA_W-1:0]  gnt_addr;
  logic               s1_vld;
  logic [PTR_W-1:0]   s1_id;

`ifdef TANH_ARB_FIXED_PRIO_EN
  assign ptr_arb = '0;
`else
  assign ptr_arb = ptr;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_arb),
    .grant (grant)
  );

  // Grants are suppressed while reset is held so nothing is accepted into a clearing pipe.
  assign req_ready = rst_n ? grant : '0;
  assign gnt_any   = |req_ready;
  assign gnt_idx   = PTR_W'(oh2idx(8'(req_ready)));
  assign gnt_addr  = req_addr[8*gnt_idx +: 8];
  assign busy      = s1_vld | (|rsp_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= '0;
      s1_vld     <= 1'b0;
      s1_id      <= '0;
      lut_addr   <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      served_cnt <= '0;
    end else begin
      s1_vld <= gnt_any;
      if (gnt_any) begin
        lut_addr <= gnt_addr;
        s1_id    <= gnt_idx;
`ifdef TANH_ARB_FIXED_PRIO_EN
        ptr      <= '0;
`else
        ptr      <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
`endif
      end
      // LUT output settled on the falling edge after lut_addr was registered.
      rsp_valid <= s1_vld ? NUM_REQ'(idx2oh(3'(s1_id))) : '0;
      if (s1_vld) begin
        rsp_data   <= lut_data;
        served_cnt <= served_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tanh_arbiter.sv
// Scoreboard bench for tanh_arbiter: grants are modelled at acceptance, responses
// are popped and compared by the same negedge monitor when rsp_valid fires.
module tb_tanh_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_addr;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [7:0]    rsp_data;
  logic [7:0]    lut_addr;
  logic [7:0]    lut_data = 8'h00;
  logic          busy;
  logic [15:0]   served_cnt;

  tanh_arbiter #(.NUM_REQ(N), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .lut_addr   (lut_addr),
    .lut_data   (lut_data),
    .busy       (busy),
    .served_cnt (served_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          mptr = 0;
  logic [15:0] mcnt = '0;
  logic [7:0]  last_data = '0;
  logic [7:0]  m_lut_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Hand-filled tanh table entries for the directed vectors; other addresses get a filler.
  function automatic logic [7:0] lut_fn(input logic [7:0] a);
    case (a)
      8'h40:   lut_fn = 8'h1D;
      8'h10:   lut_fn = 8'h07;
      8'h7F:   lut_fn = 8'h30;
      8'h80:   lut_fn = 8'hD0;
      8'hFC:   lut_fn = 8'hFF;
      8'h20:   lut_fn = 8'h0F;
      default: lut_fn = a ^ 8'h5A;
    endcase
  endfunction

  // External LUT updates on the falling edge.
  always @(negedge clk) lut_data <= lut_fn(lut_addr);

  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] mg;
    int         gi;
    logic [7:0] a;

    check("busy", {31'b0, busy}, {31'b0, q.size() != 0});
    if (rsp_valid != '0) begin
      if (q.size() == 0) begin
        check("unexpected_rsp", {28'b0, rsp_valid}, 32'h0);
      end else begin
        e = q.pop_front();
        check("rsp_valid", {28'b0, rsp_valid}, 32'h1 << e.id);
        check("rsp_data", {24'b0, rsp_data}, {24'b0, e.data});
        check("rsp_cycle", cyc, e.due);
        mcnt++;
        check("served_cnt", {16'b0, served_cnt}, {16'b0, mcnt});
        last_data = e.data;
      end
    end else begin
      check("rsp_data_hold", {24'b0, rsp_data}, {24'b0, last_data});
    end
    check("lut_addr", {24'b0, lut_addr}, {24'b0, m_lut_addr});

    if (!rst_n) begin
      check("ready_in_reset", {28'b0, req_ready}, 32'h0);
      q.delete();
      mptr       = 0;
      mcnt       = '0;
      last_data  = '0;
      m_lut_addr = '0;
    end else begin
      mg = '0;
      gi = 0;
`ifdef TANH_ARB_FIXED_PRIO_EN
      for (int j = N - 1; j >= 0; j--) begin
        if (req_valid[j]) gi = j;
      end
      if (req_valid != '0) mg[gi] = 1'b1;
`else
      for (int j = 0; j < N; j++) begin
        if (mg == '0 && req_valid[(mptr + j) % N]) begin
          gi     = (mptr + j) % N;
          mg[gi] = 1'b1;
        end
      end
`endif
      check("grant", {28'b0, req_ready}, {28'b0, mg});
      if (mg != '0) begin
        a = req_addr[8*gi +: 8];
        q.push_back('{id: gi, data: lut_fn(a), due: cyc + 2});
        m_lut_addr = a;
`ifndef TANH_ARB_FIXED_PRIO_EN
        mptr = (gi + 1) % N;
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_addr  = '0;
    tick(3);
    @(negedge clk);
    #1;
    check("rst_rsp_valid", {28'b0, rsp_valid}, 32'h0);
    check("rst_served_cnt", {16'b0, served_cnt}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_lut_addr", {24'b0, lut_addr}, 32'h0);
    check("rst_rsp_data", {24'b0, rsp_data}, 32'h0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = '0;
    tick(2);

    // Single request: requester 1, address 0x40.
    req_addr  = 32'h0000_4000;
    req_valid = 4'b0010;
    tick(1);
    req_valid = '0;
    tick(5);
    check("single_served_cnt", {16'b0, served_cnt}, 32'h1);

    // Quiet reset to bring the pointer back to 0.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // All four requesters continuously.
    req_addr  = 32'hFC80_7F10;
    req_valid = 4'hF;
    tick(8);
    req_valid = '0;
    tick(4);

    // Requester 2 streams eight back-to-back requests alone.
    req_addr  = 32'h0020_0000;
    req_valid = 4'b0100;
    tick(8);
    req_valid = '0;
    tick(4);

    // Reset while two transactions are in flight.
    req_addr  = 32'h0000_4433;
    req_valid = 4'b0011;
    tick(2);
    rst_n     = 1'b0;
    req_valid = '0;
    tick(1);
    rst_n = 1'b1;
    tick(5);
    check("flush_served_cnt", {16'b0, served_cnt}, 32'h0);
    check("flush_rsp_valid", {28'b0, rsp_valid}, 32'h0);
    req_addr  = 32'h1122_3344;
    req_valid = 4'hF;
    tick(1);
    req_valid = '0;
    tick(4);

    // Requesters 0 and 3 contend continuously.
    req_addr  = 32'h9900_0066;
    req_valid = 4'b1001;
    tick(10);
    req_valid = '0;
    tick(4);

    // Counter wrap: exactly 65536 responses after a reset.
    rst_n = 1'b0;
    tick(1);
    rst_n     = 1'b1;
    req_addr  = 32'h0000_0020;
    req_valid = 4'b0001;
    tick(65536);
    req_valid = '0;
    tick(4);
    check("wrap_served_cnt", {16'b0, served_cnt}, 32'h0);

    check("scoreboard_empty", q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
